// File: rtl/uart2wifi_core_uart_pkg.sv
// Shared FSM encoding and oversampling constants for the UART core.
package uart2wifi_core_uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned SAMPLE_TICK = 7;
  localparam int unsigned TICK_W      = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart2wifi_core_uart_fifo.sv
// Show-ahead synchronous FIFO; extra pointer bit separates full from empty.
module uart2wifi_core_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart2wifi_core_uart_param.sv
// UART core: baud divider, TX/RX FSMs with FIFOs and sticky error flags.
// Parity logic is built only when UART2WIFI_PARITY_EN is defined.
module uart2wifi_core_uart_param
  import uart2wifi_core_uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              stop2,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  output logic              tx_busy,
  input  logic              rx_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_empty,
  input  logic              rx,
  output logic              tx,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  logic par_en_c;
  logic par_odd_c;
  logic par_set_c;
  logic frame_set_c;
  logic ovr_set_c;

  // Oversample tick generator; a zero divisor stalls everything.
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;

  assign tick_c = (baud_div != '0) && (div_cnt >= baud_div - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              div_cnt <= '0;
    else if (baud_div == '0 || tick_c)    div_cnt <= '0;
    else                                  div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------- TX ----------------
  logic              tx_empty;
  logic [DATA_W-1:0] tx_head;
  logic              tx_pop_c;
  logic              tx_load_c;

  uart2wifi_core_uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_wr), .wdata(tx_data), .rd(tx_pop_c),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_state_t       tx_state, tx_state_n;
  logic [TICK_W-1:0] tx_tick, tx_tick_n;
  logic [BIT_W-1:0]  tx_bit, tx_bit_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              tx_par, tx_par_n;
  logic              tx_two_stop, tx_two_stop_n;
  logic              tx_par_en, tx_par_en_n;
  logic              tx_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state    <= ST_IDLE;
      tx_tick     <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_par_en   <= 1'b0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      tx_tick     <= tx_tick_n;
      tx_bit      <= tx_bit_n;
      tx_shift    <= tx_shift_n;
      tx_par      <= tx_par_n;
      tx_two_stop <= tx_two_stop_n;
      tx_par_en   <= tx_par_en_n;
      tx          <= tx_n;
      tx_busy     <= (tx_state_n != ST_IDLE);
    end
  end

  // Bit boundaries fall on every 16th tick; format is latched at frame load.
  always_comb begin
    tx_state_n    = tx_state;
    tx_tick_n     = tx_tick;
    tx_bit_n      = tx_bit;
    tx_shift_n    = tx_shift;
    tx_par_n      = tx_par;
    tx_two_stop_n = tx_two_stop;
    tx_par_en_n   = tx_par_en;
    tx_n          = tx;
    tx_pop_c      = 1'b0;
    tx_load_c     = 1'b0;
    if (tick_c) begin
      if (tx_state == ST_IDLE) begin
        tx_load_c = !tx_empty;
      end else if (tx_tick != TICK_W'(OVERSAMPLE - 1)) begin
        tx_tick_n = tx_tick + TICK_W'(1);
      end else begin
        tx_tick_n = '0;
        case (tx_state)
          ST_START: begin
            tx_state_n = ST_DATA;
            tx_bit_n   = '0;
            tx_n       = tx_shift[0];
          end
          ST_DATA: begin
            if (tx_bit == BIT_W'(DATA_W - 1)) begin
              tx_bit_n = '0;
              if (tx_par_en) begin
                tx_state_n = ST_PARITY;
                tx_n       = tx_par;
              end else begin
                tx_state_n = ST_STOP;
                tx_n       = 1'b1;
              end
            end else begin
              tx_shift_n = tx_shift >> 1;
              tx_bit_n   = tx_bit + BIT_W'(1);
              tx_n       = tx_shift[1];
            end
          end
          ST_PARITY: begin
            tx_state_n = ST_STOP;
            tx_bit_n   = '0;
            tx_n       = 1'b1;
          end
          ST_STOP: begin
            if (tx_two_stop && tx_bit == '0) begin
              tx_bit_n = BIT_W'(1);
            end else if (!tx_empty) begin
              tx_load_c = 1'b1;
            end else begin
              tx_state_n = ST_IDLE;
              tx_n       = 1'b1;
            end
          end
          default: tx_state_n = ST_IDLE;
        endcase
      end
    end
    if (tx_load_c) begin
      tx_pop_c      = 1'b1;
      tx_state_n    = ST_START;
      tx_tick_n     = '0;
      tx_shift_n    = tx_head;
      tx_par_n      = (^tx_head) ^ par_odd_c;
      tx_two_stop_n = stop2;
      tx_par_en_n   = par_en_c;
      tx_n          = 1'b0;
    end
  end

  // ---------------- RX ----------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  uart_state_t       rx_state, rx_state_n;
  logic [TICK_W-1:0] rx_tick, rx_tick_n;
  logic [BIT_W-1:0]  rx_bit, rx_bit_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic              rx_par_en, rx_par_en_n;
  logic              rx_par_odd, rx_par_odd_n;
  logic              rx_push, rx_push_n;
  logic [DATA_W-1:0] rx_word, rx_word_n;
  logic              rx_full;
  logic              rx_sample_c;
  logic              rx_last_c;

  assign rx_sample_c = tick_c && (rx_tick == TICK_W'(SAMPLE_TICK));
  assign rx_last_c   = tick_c && (rx_tick == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= ST_IDLE;
      rx_tick    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_push    <= 1'b0;
      rx_word    <= '0;
    end else begin
      rx_state   <= rx_state_n;
      rx_tick    <= rx_tick_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_par_en  <= rx_par_en_n;
      rx_par_odd <= rx_par_odd_n;
      rx_push    <= rx_push_n;
      rx_word    <= rx_word_n;
    end
  end

  // Tick count restarts at the detected edge; all bits sampled at tick 7.
  always_comb begin
    rx_state_n   = rx_state;
    rx_tick_n    = rx_tick;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    rx_par_en_n  = rx_par_en;
    rx_par_odd_n = rx_par_odd;
    rx_push_n    = 1'b0;
    rx_word_n    = rx_word;
    par_set_c    = 1'b0;
    frame_set_c  = 1'b0;
    if (rx_state == ST_IDLE) begin
      if (rx_prev && !rx_sync) begin
        rx_state_n   = ST_START;
        rx_tick_n    = '0;
        rx_par_en_n  = par_en_c;
        rx_par_odd_n = par_odd_c;
      end
    end else if (tick_c) begin
      rx_tick_n = rx_last_c ? '0 : rx_tick + TICK_W'(1);
      case (rx_state)
        ST_START: begin
          if (rx_sample_c && rx_sync) begin
            rx_state_n = ST_IDLE;
          end else if (rx_last_c) begin
            rx_state_n = ST_DATA;
            rx_bit_n   = '0;
          end
        end
        ST_DATA: begin
          if (rx_sample_c) rx_shift_n = {rx_sync, rx_shift[DATA_W-1:1]};
          if (rx_last_c) begin
            if (rx_bit == BIT_W'(DATA_W - 1)) rx_state_n = rx_par_en ? ST_PARITY : ST_STOP;
            else                              rx_bit_n   = rx_bit + BIT_W'(1);
          end
        end
        ST_PARITY: begin
          if (rx_sample_c) par_set_c = (rx_sync != ((^rx_shift) ^ rx_par_odd));
          if (rx_last_c)   rx_state_n = ST_STOP;
        end
        ST_STOP: begin
          if (rx_sample_c) begin
            rx_state_n = ST_IDLE;
            if (!rx_sync) begin
              frame_set_c = 1'b1;
            end else begin
              rx_push_n = 1'b1;
              rx_word_n = rx_shift;
            end
          end
        end
        default: rx_state_n = ST_IDLE;
      endcase
    end
  end

  uart2wifi_core_uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rx_push), .wdata(rx_word), .rd(rx_rd),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

  assign ovr_set_c = rx_push && rx_full;

  // Sticky flags: a new event outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set_c | (frame_err & ~err_clr);
      overrun   <= ovr_set_c | (overrun & ~err_clr);
    end
  end

`ifdef UART2WIFI_PARITY_EN
  assign par_en_c  = parity_en;
  assign par_odd_c = parity_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_set_c | (parity_err & ~err_clr);
  end
`else
  logic fmt_unused;
  assign par_en_c   = 1'b0;
  assign par_odd_c  = 1'b0;
  assign fmt_unused = parity_en ^ parity_odd ^ par_set_c;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart2wifi_core_uart_param.sv
// Randomised self-checking bench for uart2wifi_core_uart_param (FIFO_DEPTH=4).
module tb_uart2wifi_core_uart_param;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DIV_W      = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  baud_div = 16'd1;
  logic              stop2 = 1'b0;
  logic              parity_en = 1'b0;
  logic              parity_odd = 1'b0;
  logic              tx_wr = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_full, tx_busy;
  logic              rx_rd = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_empty;
  logic              rx;
  logic              tx;
  logic              err_clr = 1'b0;
  logic              frame_err, parity_err, overrun;
  logic              rx_drv = 1'b1;
  logic              loopback = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit exp_bits[$];

`ifdef UART2WIFI_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  always #5 clk = ~clk;
  assign rx = loopback ? tx : rx_drv;

  uart2wifi_core_uart_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .stop2(stop2), .parity_en(parity_en),
    .parity_odd(parity_odd), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .tx_busy(tx_busy), .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx(rx),
    .tx(tx), .err_clr(err_clr), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun)
  );

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; tx_wr = 1'b0; rx_rd = 1'b0; err_clr = 1'b0; rx_drv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reference serial frame: start, LSB-first data, optional parity, stop bit(s).
  task automatic add_frame(input logic [7:0] d, input bit par_on, input bit odd, input bit two);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par_on) exp_bits.push_back((^d) ^ odd);
    exp_bits.push_back(1'b1);
    if (two) exp_bits.push_back(1'b1);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_wr = 1'b1; tx_data = d;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic check_stream(input int bdiv, input string name);
    int n = 0;
    int bad;
    while (tx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start: tx=%b required 0 within 5000 clks", name, tx);
      return;
    end
    foreach (exp_bits[i]) begin
      bad = 0;
      for (int k = 0; k < 16 * bdiv; k++) begin
        if (tx !== exp_bits[i] || tx_busy !== 1'b1) bad++;
        @(negedge clk);
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL %s bit %0d: %0d of %0d clks off, required tx=%b busy=1", name, i, bad, 16 * bdiv, exp_bits[i]);
      end
    end
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end: tx=%b busy=%b required tx=1 busy=0", name, tx, tx_busy);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input bit with_par, input bit par_val, input bit stop_val, input int bdiv);
    rx_drv = 1'b0; repeat (16 * bdiv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; repeat (16 * bdiv) @(negedge clk); end
    if (with_par) begin rx_drv = par_val; repeat (16 * bdiv) @(negedge clk); end
    rx_drv = stop_val; repeat (16 * bdiv) @(negedge clk);
    rx_drv = 1'b1; repeat (16 * bdiv) @(negedge clk);
  endtask

  task automatic read_rx(input logic [7:0] exp, input string name);
    vectors++;
    if (rx_empty !== 1'b0 || rx_data !== exp) begin
      miscompares++;
      $display("FAIL %s: rx_empty=%b rx_data=%h required empty=0 data=%h", name, rx_empty, rx_data, exp);
    end
    rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
  endtask

  task automatic check_flags(input bit fe, input bit pe, input bit ov, input bit empty, input string name);
    vectors++;
    if (frame_err !== fe || parity_err !== pe || overrun !== ov || rx_empty !== empty) begin
      miscompares++;
      $display("FAIL %s: frame/parity/overrun/empty=%b%b%b%b required %b%b%b%b", name,
               frame_err, parity_err, overrun, rx_empty, fe, pe, ov, empty);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tx: tx/busy/full=%b%b%b required 100", tx, tx_busy, tx_full);
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx_data: %h required 00", rx_data);
    end
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "reset_flags");
    reset_dut();
  endtask

  task automatic test_tx_frame();
    reset_dut();
    baud_div = 16'd1; stop2 = 1'b0; parity_en = 1'b0;
    exp_bits.delete();
    add_frame(8'h86, 1'b0, 1'b0, 1'b0);
    fork
      write_tx(8'h86);
      check_stream(1, "tx_0x86");
    join
  endtask

  task automatic test_tx_random();
    logic [7:0] words[$];
    int bdiv;
    int nw;
    for (int r = 0; r < 3; r++) begin
      reset_dut();
      bdiv = int'($urandom_range(1, 3));
      nw = int'($urandom_range(1, 4));
      baud_div = DIV_W'(bdiv);
      stop2 = 1'($urandom_range(0, 1));
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      words.delete(); exp_bits.delete();
      for (int i = 0; i < nw; i++) begin
        words.push_back(8'($urandom));
        add_frame(words[i], PAR_BUILT && parity_en, parity_odd, stop2);
      end
      fork
        begin foreach (words[i]) write_tx(words[i]); end
        check_stream(bdiv, $sformatf("tx_rand%0d", r));
      join
    end
    parity_en = 1'b0; stop2 = 1'b0;
  endtask

  task automatic test_baud();
    int n;
    reset_dut();
    baud_div = 16'd163;
    write_tx(8'hFF);
    n = 0;
    while (tx !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (tx === 1'b0 && n < 5000) begin @(negedge clk); n++; end
    vectors++;
    if (n != 163 * 16) begin
      miscompares++;
      $display("FAIL baud_163: start bit %0d clks required %0d", n, 163 * 16);
    end
    reset_dut();
    baud_div = 16'd0;
    write_tx(8'h00);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL baud_zero: %0d of 1000 clks active, required 0", n);
    end
    baud_div = 16'd1;
    reset_dut();
  endtask

  task automatic wait_tx_done(input int bdiv);
    int n = 0;
    repeat (2 * bdiv + 4) @(negedge clk);
    while (tx_busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_drain: busy=%b required 0", tx_busy);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] words[$];
    reset_dut();
    loopback = 1'b1; baud_div = 16'd1; stop2 = 1'b0; parity_en = 1'b0;
    write_tx(8'h61);
    write_tx(8'hFA);
    wait_tx_done(1);
    read_rx(8'h61, "loop_0x61");
    read_rx(8'hFA, "loop_0xFA");
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "loop_fixed_flags");
    baud_div = DIV_W'($urandom_range(1, 2));
    stop2 = 1'($urandom_range(0, 1));
    parity_en = 1'($urandom_range(0, 1));
    parity_odd = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) words.push_back(8'($urandom));
    foreach (words[i]) write_tx(words[i]);
    wait_tx_done(int'(baud_div));
    foreach (words[i]) read_rx(words[i], $sformatf("loop_rand%0d", i));
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "loop_rand_flags");
    loopback = 1'b0; parity_en = 1'b0; stop2 = 1'b0; baud_div = 16'd1;
  endtask

  task automatic test_rx_errors();
    reset_dut();
    send_rx(8'h3C, 1'b0, 1'b0, 1'b0, 1);
    check_flags(1'b1, 1'b0, 1'b0, 1'b1, "frame_err_set");
    send_rx(8'hA5, 1'b0, 1'b0, 1'b1, 1);
    check_flags(1'b1, 1'b0, 1'b0, 1'b0, "frame_err_sticky");
    read_rx(8'hA5, "after_frame_err");
    pulse_err_clr();
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "frame_err_clr");
    rx_drv = 1'b0; repeat (4) @(negedge clk);
    rx_drv = 1'b1; repeat (200) @(negedge clk);
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "false_start");
    send_rx(8'h5A, 1'b0, 1'b0, 1'b1, 1);
    read_rx(8'h5A, "after_false_start");
  endtask

  task automatic test_overrun();
    logic [7:0] words[$];
    reset_dut();
    for (int i = 0; i < 5; i++) words.push_back(8'($urandom));
    foreach (words[i]) send_rx(words[i], 1'b0, 1'b0, 1'b1, 1);
    repeat (10) @(negedge clk);
    check_flags(1'b0, 1'b0, 1'b1, 1'b0, "overrun_set");
    for (int i = 0; i < 4; i++) read_rx(words[i], $sformatf("overrun_word%0d", i));
    check_flags(1'b0, 1'b0, 1'b1, 1'b1, "overrun_drained");
    pulse_err_clr();
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "overrun_clr");
  endtask

  task automatic test_parity();
    reset_dut();
    parity_en = 1'b1; parity_odd = 1'b1;
`ifdef UART2WIFI_PARITY_EN
    send_rx(8'h61, 1'b1, ^8'h61, 1'b1, 1);
    check_flags(1'b0, 1'b1, 1'b0, 1'b0, "parity_err_set");
    read_rx(8'h61, "parity_word");
    pulse_err_clr();
    check_flags(1'b0, 1'b0, 1'b0, 1'b1, "parity_err_clr");
    send_rx(8'h61, 1'b1, ~(^8'h61), 1'b1, 1);
    check_flags(1'b0, 1'b0, 1'b0, 1'b0, "parity_good");
    read_rx(8'h61, "parity_good_word");
`else
    send_rx(8'h61, 1'b0, 1'b0, 1'b1, 1);
    check_flags(1'b0, 1'b0, 1'b0, 1'b0, "parity_ignored");
    read_rx(8'h61, "parity_ignored_word");
`endif
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    reset_dut();
    baud_div = 16'd1;
    write_tx(8'h00);
    write_tx(8'h00);
    repeat (40) @(negedge clk);
    vectors++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_tx_active: tx=%b busy=%b required 0 1", tx, tx_busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_tx_reset: tx/busy/full=%b%b%b required 100", tx, tx_busy, tx_full);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_tx_after: tx=%b busy=%b required 1 0", tx, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_random();
    test_baud();
    test_loopback();
    test_rx_errors();
    test_overrun();
    test_parity();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
